alu_div: RTL

- Multi-cycle 32-bit integer divider for DIV/DIVU; produces the HI/LO write interface (`o_we`, `o_hi`, `o_lo`) that feeds the HILO register.
- Sits in the EX stage beside the logic and arithmetic ALUs. Raises a stall request while iterating, then presents remainder on `o_hi` and quotient on `o_lo` with a one-cycle write strobe.
- Uses radix-2 restoring division, one quotient bit per cycle.

---
 rtl/alu_div.sv | 134 +++++++++++++
 1 files changed

// File: rtl/alu_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. It produces one quotient bit
// per cycle and presents the remainder on o_hi and the quotient on o_lo for the HI/LO write.
module alu_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_we,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dq_q, dq_d;    // dividend bits shift out of the top, quotient bits shift in at the bottom
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             sgn_q, sgn_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] abs_dvd, abs_dsr;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_new, quo_new;

    always_comb begin
        abs_dvd = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        abs_dsr = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
        rem_sh  = {rem_q, dq_q[WIDTH-1]};
        ge      = (rem_sh >= {1'b0, dsr_q});
        // The result is smaller than the divisor, so the truncated difference is exact.
        rem_new = ge ? (rem_sh[WIDTH-1:0] - dsr_q) : rem_sh[WIDTH-1:0];
        quo_new = {dq_q[WIDTH-2:0], ge};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        sgn_d   = sgn_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    if (divisor == '0) begin
                        state_d = DONE;
                        lo_d    = '1;
                        hi_d    = dividend;
                    end else begin
                        state_d = CALC;
                        cnt_d   = '0;
                        dq_d    = abs_dvd;
                        dsr_d   = abs_dsr;
                        rem_d   = '0;
                        sgn_d   = signed_op;
                        qsign_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rsign_d = dividend[WIDTH-1];
                    end
                end
            end
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    dq_d  = quo_new;
                    rem_d = rem_new;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        lo_d    = (sgn_q && qsign_q) ? -quo_new : quo_new;
                        hi_d    = (sgn_q && rsign_q) ? -rem_new : rem_new;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            sgn_q   <= 1'b0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            sgn_q   <= sgn_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // The stall drops in DONE so the instruction advances while the write is presented.
    assign o_stall = ((state_q == IDLE) && start && !cancel) || (state_q == CALC);
    assign o_busy  = (state_q != IDLE);
    assign o_we    = (state_q == DONE) && !cancel;
    assign o_hi    = hi_q;
    assign o_lo    = lo_q;

endmodule
